// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl_pkg
//  Description : Shared definitions for the core run/halt/step sequencer:
//                FSM state encoding and default timing parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    // State encoding is visible on the board LEDs, so the values are fixed.
    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } run_state_e;

    localparam int DEF_CLK_DIV         = 25_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_CNT_W           = 32;

endpackage
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : input_debounce
//  Description : Two-flop synchronizer followed by a debouncer. The output
//                follows the synchronized input only after it has differed
//                from the current output for DEBOUNCE_CYCLES consecutive
//                clocks; any bounce back restarts the count.
//  Revision    : 1.0 - initial release
//  Ports       : clk   - board clock
//                reset - asynchronous active-low reset
//                din   - raw asynchronous input
//                dout  - debounced, clock-domain-safe level
// ============================================================================
module input_debounce
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          dout_q;
    logic          dout_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count records how many cycles the synchronized value has already
    // disagreed with the output; the change is accepted on the cycle that
    // completes the DEBOUNCE_CYCLES-th disagreement.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = '0;
        if (sync2_q != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : core_run_ctrl
//  Description : Run/halt/single-step sequencer for the pipelined RISC-V
//                datapath. Issues single-cycle clock-enable pulses, stops on a
//                writeback halt request and counts issued core cycles.
//  Revision    : 1.0 - initial release
//  Build macro : BREAKPOINT_EN - adds pc/bp_addr/bp_valid breakpoint halt
//  Ports       : clk       - board clock
//                reset     - asynchronous active-low reset
//                switch    - raw run/halt switch (1 = run)
//                step      - raw single-step pushbutton (1 = pressed)
//                halt_req  - datapath halt, sampled only while core_en=1
//                core_en   - registered datapath clock enable pulse
//                state     - current FSM state for LEDs
//                cycle_cnt - saturating count of core_en pulses
//                done      - high while in DONE
//                pc, bp_addr, bp_valid - breakpoint inputs (BREAKPOINT_EN)
// ============================================================================
module core_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CLK_DIV         = DEF_CLK_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             switch,
    input  logic             step,
    input  logic             halt_req,
`ifdef BREAKPOINT_EN
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
`endif
    output logic             core_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done
);

    localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic w_switch_db;
    logic w_step_db;
    logic w_step_rise;
    logic w_bp_hit;
    logic w_run_ok;

    run_state_e       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             core_en_q, core_en_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_db_q;

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_switch (
        .clk   (clk),
        .reset (reset),
        .din   (switch),
        .dout  (w_switch_db)
    );

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .din   (step),
        .dout  (w_step_db)
    );

    assign w_step_rise = w_step_db & ~step_db_q;

`ifdef BREAKPOINT_EN
    // After a breakpoint stop the switch is still high; RUN may only be
    // re-entered once the switch has been seen low again.
    logic bp_hold_q, bp_hold_d;

    assign w_bp_hit = core_en_q & bp_valid & (pc == bp_addr);
    assign w_run_ok = ~bp_hold_q;

    always_comb begin
        bp_hold_d = bp_hold_q;
        if (state_q == ST_RUN && !(core_en_q && halt_req) && w_bp_hit) begin
            bp_hold_d = 1'b1;
        end
        if (!w_switch_db) begin
            bp_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_hold_q <= 1'b0;
        end else begin
            bp_hold_q <= bp_hold_d;
        end
    end
`else
    assign w_bp_hit = 1'b0;
    assign w_run_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HALT: begin
                if (w_switch_db && w_run_ok) begin
                    state_d = ST_RUN;
                end else if (w_step_rise) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (core_en_q && halt_req) begin
                    state_d = ST_DONE;
                end else if (w_bp_hit) begin
                    state_d = ST_HALT;
                end else if (!w_switch_db) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                state_d = halt_req ? ST_DONE : ST_HALT;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Prescaler only advances while staying in RUN, so every entry
        // starts a fresh CLK_DIV-cycle wait and a leave discards the count.
        presc_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
        end

        core_en_d = (state_d == ST_STEP) ||
                    (state_q == ST_RUN && state_d == ST_RUN && presc_q == PRE_LAST);

        done_d = (state_d == ST_DONE);

        cnt_d = cnt_q;
        if (core_en_q && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_HALT;
            presc_q   <= '0;
            core_en_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            step_db_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            core_en_q <= core_en_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            step_db_q <= w_step_db;
        end
    end

    assign core_en   = core_en_q;
    assign state     = state_q;
    assign cycle_cnt = cnt_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_core_run_ctrl
//  Description : Self-checking bench for core_run_ctrl with CLK_DIV=4 and
//                DEBOUNCE_CYCLES=3. A second instance with a 3-bit counter
//                shares all inputs for the saturation scenario. Expected
//                core_en pulse cycles are queued when stimulus is applied and
//                matched by a monitor as pulses appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_run_ctrl;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       switch   = 1'b0;
    logic       step     = 1'b0;
    logic       halt_req = 1'b0;

    logic       core_en, done, core_en_s, done_s;
    logic [1:0] state, state_s;
    logic [7:0] cycle_cnt;
    logic [2:0] cycle_cnt_s;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_q[$];
    int mon_e;
    logic prev_en = 1'b0;

    core_run_ctrl #(.CLK_DIV(4), .DEBOUNCE_CYCLES(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .switch(switch), .step(step), .halt_req(halt_req),
        .core_en(core_en), .state(state), .cycle_cnt(cycle_cnt), .done(done)
    );

    core_run_ctrl #(.CLK_DIV(4), .DEBOUNCE_CYCLES(3), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .switch(switch), .step(step), .halt_req(halt_req),
        .core_en(core_en_s), .state(state_s), .cycle_cnt(cycle_cnt_s), .done(done_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every core_en pulse must match the next queued cycle.
    always @(negedge clk) begin
        if (core_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: core_en=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e != cyc) begin
                    errors++;
                    $display("FAIL pulse_time: pulse at cycle %0d, required cycle %0d", cyc, mon_e);
                end
            end
            checks++;
            if (prev_en) begin
                errors++;
                $display("FAIL pulse_width: core_en high two cycles at %0d, required single-cycle", cyc);
            end
        end
        prev_en <= core_en;
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; switch = 1'b0; step = 1'b0; halt_req = 1'b0;
        clk_n(2);
        reset = 1'b1;
        clk_n(1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clk_n(3);
        checks++;
        if (state !== 2'b00 || core_en !== 1'b0 || cycle_cnt !== 8'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%b en=%b cnt=%0d done=%b, required 00/0/0/0",
                     state, core_en, cycle_cnt, done);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            clk_n(1);
            checks++;
            if (state !== 2'b00 || core_en !== 1'b0 || cycle_cnt !== 8'd0) begin
                errors++;
                $display("FAIL idle: clk %0d state=%b en=%b cnt=%0d, required 00/0/0",
                         i, state, core_en, cycle_cnt);
            end
        end
    endtask

    task automatic test_run_cadence();
        int p;
        do_reset();
        switch = 1'b1;
        p = cyc;
        for (int k = 0; k < 5; k++) exp_q.push_back(p + 10 + 4 * k);
        clk_n(5);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL run_early: state=%b 5 clocks after switch, required 00", state);
        end
        clk_n(1);
        checks++;
        if (state !== 2'b01 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL run_entry: state=%b en=%b 6 clocks after switch, required 01/0", state, core_en);
        end
        clk_n(16);
        switch = 1'b0;
        clk_n(6);
        checks++;
        if (state !== 2'b00 || cycle_cnt !== 8'd5) begin
            errors++;
            $display("FAIL run_stop: state=%b cnt=%0d, required 00/5", state, cycle_cnt);
        end
        clk_n(8);
        checks++;
        if (exp_q.size() != 0 || cycle_cnt !== 8'd5) begin
            errors++;
            $display("FAIL run_pulses: %0d pulses missing cnt=%0d, required 0 missing cnt=5",
                     exp_q.size(), cycle_cnt);
        end
    endtask

    task automatic test_bounce_and_step();
        int p;
        do_reset();
        switch = 1'b1; clk_n(1);
        switch = 1'b0; clk_n(1);
        switch = 1'b1; clk_n(1);
        switch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_n(1);
            checks++;
            if (state !== 2'b00) begin
                errors++;
                $display("FAIL bounce: clk %0d state=%b, required 00", i, state);
            end
        end
        step = 1'b1;
        p = cyc;
        exp_q.push_back(p + 6);
        clk_n(5);
        step = 1'b0;
        clk_n(1);
        checks++;
        if (state !== 2'b10 || core_en !== 1'b1) begin
            errors++;
            $display("FAIL step_state: state=%b en=%b, required 10/1", state, core_en);
        end
        clk_n(1);
        checks++;
        if (state !== 2'b00 || core_en !== 1'b0 || cycle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL step_return: state=%b en=%b cnt=%0d, required 00/0/1", state, core_en, cycle_cnt);
        end
        clk_n(10);
        checks++;
        if (exp_q.size() != 0 || cycle_cnt !== 8'd1 || state !== 2'b00) begin
            errors++;
            $display("FAIL step_once: missing=%0d cnt=%0d state=%b, required 0/1/00",
                     exp_q.size(), cycle_cnt, state);
        end
    endtask

    task automatic test_halt();
        int p;
        do_reset();
        switch = 1'b1;
        p = cyc;
        exp_q.push_back(p + 10);
        exp_q.push_back(p + 14);
        exp_q.push_back(p + 18);
        clk_n(12);
        halt_req = 1'b1;              // no pulse this cycle: must be ignored
        clk_n(1);
        halt_req = 1'b0;
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL halt_unsampled: state=%b, required 01", state);
        end
        clk_n(5);
        halt_req = 1'b1;
        clk_n(1);
        halt_req = 1'b0;
        checks++;
        if (state !== 2'b11 || done !== 1'b1 || cycle_cnt !== 8'd3 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_done: state=%b done=%b cnt=%0d en=%b, required 11/1/3/0",
                     state, done, cycle_cnt, core_en);
        end
        switch = 1'b0; step = 1'b1;
        clk_n(12);
        switch = 1'b1; step = 1'b0;
        clk_n(12);
        checks++;
        if (state !== 2'b11 || done !== 1'b1 || cycle_cnt !== 8'd3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_sticky: state=%b done=%b cnt=%0d missing=%0d, required 11/1/3/0",
                     state, done, cycle_cnt, exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int p;
        do_reset();
        switch = 1'b1; step = 1'b1;
        p = cyc;
        exp_q.push_back(p + 10);
        exp_q.push_back(p + 14);
        clk_n(6);
        checks++;
        if (state !== 2'b01 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL run_over_step: state=%b en=%b, required 01/0", state, core_en);
        end
        clk_n(3);
        switch = 1'b0;
        clk_n(5);
        halt_req = 1'b1;
        checks++;
        if (state !== 2'b01 || core_en !== 1'b1) begin
            errors++;
            $display("FAIL sim_pulse: state=%b en=%b, required 01/1", state, core_en);
        end
        clk_n(1);
        halt_req = 1'b0;
        checks++;
        if (state !== 2'b11 || cycle_cnt !== 8'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL halt_over_switch: state=%b cnt=%0d missing=%0d, required 11/2/0",
                     state, cycle_cnt, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        int p;
        do_reset();
        switch = 1'b1;
        p = cyc;
        exp_q.push_back(p + 10);
        clk_n(14);
        checks++;
        if (core_en !== 1'b1 || cycle_cnt !== 8'd1 || state !== 2'b01) begin
            errors++;
            $display("FAIL pre_reset: en=%b cnt=%0d state=%b, required 1/1/01", core_en, cycle_cnt, state);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (core_en !== 1'b0 || cycle_cnt !== 8'd0 || state !== 2'b00 || core_en_s !== 1'b0 ||
            exp_q.size() != 0) begin
            errors++;
            $display("FAIL async_reset: en=%b cnt=%0d state=%b en_s=%b missing=%0d, required 0/0/00/0/0",
                     core_en, cycle_cnt, state, core_en_s, exp_q.size());
        end
        switch = 1'b0;
        clk_n(2);
        reset = 1'b1;
        clk_n(1);
    endtask

    task automatic test_saturation();
        int p;
        do_reset();
        switch = 1'b1;
        p = cyc;
        for (int k = 0; k < 9; k++) exp_q.push_back(p + 10 + 4 * k);
        clk_n(38);
        switch = 1'b0;
        clk_n(6);
        checks++;
        if (cycle_cnt_s !== 3'd7 || state_s !== 2'b00 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL saturate: cnt3=%0d state=%b done=%b, required 7/00/0", cycle_cnt_s, state_s, done_s);
        end
        checks++;
        if (cycle_cnt !== 8'd9 || state !== 2'b00 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL nine_pulses: cnt=%0d state=%b missing=%0d, required 9/00/0",
                     cycle_cnt, state, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_run_cadence();
        test_bounce_and_step();
        test_halt();
        test_simultaneous();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
